// File: rtl/signed_accumulator_pkg.sv
// Shared definitions for the signed accumulator slice.
//   op_e          : transaction opcode carried on in_op
//   DEFAULT_WIDTH : default operand/accumulator width
//   SMAX / SMIN   : signed limits of a DEFAULT_WIDTH-bit two's-complement value
package signed_accumulator_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int          SMAX          = 2**(DEFAULT_WIDTH-1) - 1;
  localparam int          SMIN          = -(2**(DEFAULT_WIDTH-1));

endpackage

// File: rtl/signed_accumulator_opposite_number_ext.sv
// opposite_number_ext: exact combinational negator, WIDTH -> WIDTH+1 bits.
// The extra bit keeps -(most negative) representable (e.g. -(-128) = +128).
//   a_i   : signed WIDTH-bit operand
//   neg_o : signed WIDTH+1-bit negation of a_i
module opposite_number_ext #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH:0]   neg_o
);

  logic [WIDTH:0] ext;

  assign ext   = {a_i[WIDTH-1], a_i};
  assign neg_o = '0 - ext;

endmodule

// File: rtl/signed_accumulator.sv
// signed_accumulator: two-stage pipelined add/sub/load/clear accumulator with
// overflow detection, sticky overflow and optional saturation.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : operand transaction valid
//   in_ready    : pipeline can advance (global stall, no skid buffer)
//   in_op       : 00 add, 01 sub, 10 load, 11 clear
//   in_data     : signed operand
//   out_valid   : result valid
//   out_ready   : downstream accepts result
//   out_acc     : accumulator after the transaction
//   out_ovf     : overflow on this transaction
//   ovf_sticky  : OR of out_ovf since last clear/reset
module signed_accumulator
  import signed_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter logic        SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_ovf,
  output logic             ovf_sticky
);

  // Limits sign-extended to the WIDTH+2-bit sum domain.
  localparam logic signed [WIDTH+1:0] SMAX_X = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SMIN_X = {3'b111, {(WIDTH-1){1'b0}}};

  logic             adv;
  op_e              op_in;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   neg;

  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH:0]   s1_opnd_d;
  logic [WIDTH:0]   s1_opnd_q;

  logic                    out_valid_q;
  logic [WIDTH-1:0]        acc_q;
  logic [WIDTH-1:0]        acc_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    sticky_q;
  logic                    sticky_d;
  logic signed [WIDTH+1:0] sum;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign op_in    = op_e'(in_op);
  assign ext      = {in_data[WIDTH-1], in_data};

  opposite_number_ext #(.WIDTH(WIDTH)) u_neg (
    .a_i   (in_data),
    .neg_o (neg)
  );

  // Stage 1: operand conditioning.
  always_comb begin
    s1_opnd_d = ext;
    case (op_in)
      OP_SUB:  s1_opnd_d = neg;
      OP_CLR:  s1_opnd_d = '0;
      default: s1_opnd_d = ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_opnd_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_op_q    <= op_in;
      s1_opnd_q  <= s1_opnd_d;
    end
  end

  // Stage 2: accumulate. Sum is formed in WIDTH+2 bits so neither the
  // WIDTH+1-bit operand nor the range check can wrap.
  always_comb begin
    sum      = $signed({acc_q[WIDTH-1], acc_q[WIDTH-1], acc_q})
             + $signed({s1_opnd_q[WIDTH], s1_opnd_q});
    acc_d    = acc_q;
    ovf_d    = 1'b0;
    sticky_d = sticky_q;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        ovf_d = (sum > SMAX_X) || (sum < SMIN_X);
        if (ovf_d && SATURATE)
          acc_d = sum[WIDTH+1] ? SMIN_X[WIDTH-1:0] : SMAX_X[WIDTH-1:0];
        else
          acc_d = sum[WIDTH-1:0];
        sticky_d = sticky_q | ovf_d;
      end
      OP_LOAD: acc_d = s1_opnd_q[WIDTH-1:0];
      OP_CLR: begin
        acc_d    = '0;
        sticky_d = 1'b0;
      end
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc_q    <= acc_d;
        ovf_q    <= ovf_d;
        sticky_q <= sticky_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_acc    = acc_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed bench for signed_accumulator: one wrapping (u0) and one saturating
// (u1) instance driven by the same stimulus.
module tb_signed_accumulator;
  import signed_accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_ovf0, sticky0;
  logic [7:0] acc0;
  logic       in_ready1, out_valid1, out_ovf1, sticky1;
  logic [7:0] acc1;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [7:0] got [8];
  int                ngot;
  int                sent;
  logic              acc_c;

  always #5 clk = ~clk;

  signed_accumulator #(.WIDTH(8), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_acc(acc0), .out_ovf(out_ovf0),
    .ovf_sticky(sticky0)
  );

  signed_accumulator #(.WIDTH(8), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid1),
    .out_ready(out_ready), .out_acc(acc1), .out_ovf(out_ovf1),
    .ovf_sticky(sticky1)
  );

  task automatic chk(input string tag, input logic signed [15:0] obs,
                     input logic signed [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input int data);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = 8'(data);
    tick();
  endtask

  task automatic idle;
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = OP_ADD; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", out_valid0, 0);
    chk("rst_acc", $signed(acc0), 0);
    chk("rst_ovf", out_ovf0, 0);
    chk("rst_sticky", sticky0, 0);
    chk("rst_ready", in_ready0, 1);
    rst = 1'b0;

    // load 5, add 3, sub 10
    issue(OP_LOAD, 5);
    chk("lat_valid", out_valid0, 0);
    issue(OP_ADD, 3);
    chk("seq1_valid", out_valid0, 1);
    chk("seq1_acc", $signed(acc0), 5);
    issue(OP_SUB, 10);
    chk("seq2_acc", $signed(acc0), 8);
    chk("seq2_ovf", out_ovf0, 0);
    idle();
    chk("seq3_acc", $signed(acc0), -2);
    chk("seq3_ovf", out_ovf0, 0);
    chk("seq3_valid", out_valid0, 1);
    idle();
    chk("drain_valid", out_valid0, 0);
    chk("drain_hold", $signed(acc0), -2);

    // 127 + 1 : wrap vs saturate, then clear
    issue(OP_LOAD, 127);
    issue(OP_ADD, 1);
    chk("ld127", $signed(acc0), 127);
    issue(OP_CLR, 0);
    chk("wrap_acc", $signed(acc0), -128);
    chk("wrap_ovf", out_ovf0, 1);
    chk("wrap_sticky", sticky0, 1);
    chk("sat_hi_acc", $signed(acc1), SMAX);
    chk("sat_hi_ovf", out_ovf1, 1);
    idle();
    chk("clr_acc", $signed(acc0), 0);
    chk("clr_sticky", sticky0, 0);
    chk("clr_ovf", out_ovf0, 0);
    chk("clr_sticky1", sticky1, 0);

    // 0 - (-128) and -100 - 100
    issue(OP_LOAD, 0);
    issue(OP_SUB, -128);
    chk("ld0", $signed(acc1), 0);
    issue(OP_LOAD, -100);
    chk("sub_m128_sat", $signed(acc1), 127);
    chk("sub_m128_sat_ovf", out_ovf1, 1);
    chk("sub_m128_wrap", $signed(acc0), -128);
    chk("sub_m128_wrap_ovf", out_ovf0, 1);
    issue(OP_SUB, 100);
    chk("ldm100", $signed(acc1), -100);
    chk("ldm100_ovf", out_ovf1, 0);
    idle();
    chk("sat_lo_acc", $signed(acc1), SMIN);
    chk("sat_lo_ovf", out_ovf1, 1);
    chk("wrap_lo_acc", $signed(acc0), 56);
    chk("wrap_lo_ovf", out_ovf0, 1);

    // -1 - (-128) = 127 exactly, no overflow; sticky survives
    issue(OP_LOAD, -1);
    chk("gap_valid", out_valid0, 0);
    issue(OP_SUB, -128);
    chk("ldm1", $signed(acc0), -1);
    idle();
    chk("edge_acc0", $signed(acc0), 127);
    chk("edge_ovf0", out_ovf0, 0);
    chk("edge_acc1", $signed(acc1), 127);
    chk("edge_ovf1", out_ovf1, 0);
    chk("edge_sticky0", sticky0, 1);
    idle();

    // every operand added to zero
    for (int v = -128; v <= 127; v++) begin
      issue(OP_CLR, 0);
      issue(OP_ADD, v);
      idle();
      idle();
      chk("sweep_acc0", $signed(acc0), 16'(v));
      chk("sweep_ovf0", out_ovf0, 0);
      chk("sweep_acc1", $signed(acc1), 16'(v));
      chk("sweep_sticky0", sticky0, 0);
    end

    // backpressure: 4 adds of 1, out_ready low on cycles 3..5
    issue(OP_CLR, 0);
    idle();
    idle();
    sent = 0;
    ngot = 0;
    for (int c = 1; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 4);
      in_op     = OP_ADD;
      in_data   = 8'd1;
      #1;
      if (c >= 3 && c <= 5) begin
        chk("bp_ready", in_ready0, 0);
        chk("bp_valid", out_valid0, 1);
        chk("bp_hold", $signed(acc0), 1);
      end
      acc_c = in_valid & in_ready0;
      if (out_valid0 && out_ready && ngot < 8) begin
        got[ngot] = acc0;
        ngot++;
      end
      @(posedge clk);
      #1;
      if (acc_c) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 16'(ngot), 4);
    chk("bp_r0", got[0], 1);
    chk("bp_r1", got[1], 2);
    chk("bp_r2", got[2], 3);
    chk("bp_r3", got[3], 4);

    // reset with transactions in flight
    issue(OP_ADD, 5);
    issue(OP_ADD, 6);
    chk("pre_rst_acc", $signed(acc0), 9);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid0, 0);
    chk("mid_rst_acc", $signed(acc0), 0);
    issue(OP_ADD, 7);
    chk("post_rst_quiet", out_valid0, 0);
    idle();
    chk("post_rst_acc", $signed(acc0), 7);
    chk("post_rst_valid", out_valid0, 1);
    idle();
    chk("post_rst_drain", out_valid0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/signed_accumulator.md
Name: signed_accumulator

Overview:
- Pipelined signed add/subtract accumulator that sits directly downstream of the opposite_number negation stage.
- Consumes a stream of two's-complement operands and adds each one to a running total, or subtracts it, per transaction.
- Negation is exact: negating -128 gives +128 internally, not a wrap back to -128.
- Reports a sticky overflow flag and optionally saturates the total. Used as the arithmetic core for the counter and ALU exercises.

Parameters:
WIDTH, 8, operand and accumulator width in bits (signed two's complement)
SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept an operand this cycle
in_op  input  2  00 = add, 01 = sub, 10 = load, 11 = clear
in_data  input  WIDTH  signed operand
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_acc  output  WIDTH  accumulator value after this transaction
out_ovf  output  1  overflow occurred on this transaction
ovf_sticky  output  1  OR of out_ovf since the last clear or reset

Behaviour:
- Reset, checked at the clk edge while rst = 1:
  - out_valid = 0, out_acc = 0, out_ovf = 0, ovf_sticky = 0.
  - Accumulator = 0, stage-1 valid = 0.
  - A reset mid-operation discards any in-flight transactions; nothing is emitted for them.
- Pipeline enable: adv = ~out_valid | out_ready.
  - in_ready = adv, so the stall is global and there is no skid buffer.
  - A transaction is accepted on in_valid & in_ready.
- Stage 1 (register, loads when adv):
  - Sign-extend in_data to WIDTH+1 bits, giving operand e.
  - sub: store -e, computed in WIDTH+1 bits (exact, so -(-128) = +128).
  - add and load: store e.
  - clear: store 0.
  - Store op and s1_valid = accepted.
- Stage 2 (register, loads when adv and s1_valid):
  - add and sub:
    - sum = acc + s1_operand, computed in WIDTH+2 bits.
    - ovf = (sum > 2^(WIDTH-1)-1) or (sum < -2^(WIDTH-1)).
  - load: acc = low WIDTH bits of s1_operand, ovf = 0.
  - clear: acc = 0, ovf = 0, ovf_sticky cleared.
  - On overflow:
    - SATURATE = 1: acc clamps to +max (sum positive) or -min (sum negative).
    - SATURATE = 0: acc = sum[WIDTH-1:0].
  - out_acc = new acc, out_ovf = ovf, ovf_sticky |= ovf (except on clear), out_valid = 1.
- When adv = 1 and s1_valid = 0: out_valid goes to 0 and out_acc holds its value.
- When adv = 0: both stages hold and all outputs are stable until out_ready.
- Latency:
  - The result appears 2 cycles after acceptance.
  - Throughput is 1 per cycle while out_ready = 1.
  - Results leave in acceptance order, one result per accepted transaction.
- Back-to-back dependent ops are correct: stage 2 always uses the acc just written, with no hazards.

Decomposition:
- Shared package:
  - op encoding constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLR).
  - WIDTH-derived localparams SMAX = 2^(WIDTH-1)-1 and SMIN = -2^(WIDTH-1).
- One natural sub-module: opposite_number_ext, the exact WIDTH to WIDTH+1 negator used in stage 1.
  - It is combinational and the sibling of the existing opposite_number.
- The saturation and overflow logic stays inline in stage 2.

Test Plan:
- rst held 2 cycles, then load 5, add 3, sub 10 with out_ready = 1 -> out_acc = 5, 8, -2 on consecutive cycles, first result 2 cycles after first accept, out_ovf = 0 throughout.
- SATURATE = 0: load 127, add 1 -> out_acc = -128, out_ovf = 1, ovf_sticky = 1; then clear -> out_acc = 0, ovf_sticky = 0.
- SATURATE = 1: load 0, sub -128 -> out_acc = 127, out_ovf = 1; load -100, sub 100 -> out_acc = -128, out_ovf = 1.
- Edge operands: load -1, sub -128 -> out_acc = 127, out_ovf = 0. Also sweep every operand -128..127 with the add op from acc = 0 -> out_acc = operand, no overflow.
- Backpressure: stream 4 adds of 1 with out_ready low on cycles 3-5 -> in_ready low on those cycles, out_acc held stable, final sequence 1, 2, 3, 4 with no loss or duplication.
- Mid-stream reset: assert rst with 2 transactions in flight -> next cycle out_valid = 0, out_acc = 0, and the next add 7 yields out_acc = 7.
